// File: rtl/uart_rx_buffer_if.sv
// Bus-side and receiver-side signals of the RX buffer. The slave modport is the
// buffer itself; the master modport is whatever drives the strobes and controls.
interface uart_rx_buffer_if;
  logic       rWR;
  logic       rRD;
  logic       lsr_rd;
  logic [7:0] datain;
  logic       pe_in;
  logic       fe_in;
  logic [7:0] FCR;
  logic [7:0] IER;
  logic [7:0] dataout;
  logic [7:0] IIR;
  logic [7:0] LSR;

  // Strobes are single-cycle pulses sampled on the rising clock edge; there is
  // no back-pressure, so a push into a full buffer is dropped and flagged as overrun.
  modport slave (
    input  rWR, rRD, lsr_rd, datain, pe_in, fe_in, FCR, IER,
    output dataout, IIR, LSR
  );

  modport master (
    output rWR, rRD, lsr_rd, datain, pe_in, fe_in, FCR, IER,
    input  dataout, IIR, LSR
  );
endinterface

// File: rtl/uart_rx_buffer.sv
// 16-entry UART receive FIFO with 16550-style line status, trigger-level
// and character-timeout interrupt identification. All outputs are registered.
module uart_rx_buffer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic            clk,
  input logic            reset,
  uart_rx_buffer_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [9:0]    mem [16];
  logic [3:0]    wptr, rptr;
  logic [4:0]    count, err_cnt;
  logic [TW-1:0] idle_cnt;
  logic          to_flag;
  logic [7:0]    dout_q, lsr_q, iir_q;

  logic          clear, push_ok, pop_ok, overrun, push_err, pop_err;
  logic [4:0]    remain, count_n, err_n, trig;
  logic [3:0]    wptr_n, rptr_n;
  logic [9:0]    pop_entry, head_n;
  logic [TW-1:0] idle_n;
  logic          to_n;
  logic [7:0]    lsr_n, iir_n;
  logic          unused_bits;

  assign unused_bits = ^{bus.FCR[5:2], bus.IER[7:3], bus.IER[1]};
  assign bus.dataout = dout_q;
  assign bus.LSR     = lsr_q;
  assign bus.IIR     = iir_q;

  always_comb begin
    clear     = !bus.FCR[0] || bus.FCR[1];
    pop_entry = mem[rptr];
    // A push into a full buffer still lands when a pop frees the slot on the same edge.
    push_ok   = bus.rWR && ((count != 5'd16) || bus.rRD);
    pop_ok    = bus.rRD && (count != 5'd0);
    overrun   = bus.rWR && (count == 5'd16) && !bus.rRD;
    push_err  = push_ok && (bus.pe_in || bus.fe_in);
    pop_err   = pop_ok && (pop_entry[8] || pop_entry[9]);
    remain    = count - {4'd0, pop_ok};
    count_n   = remain + {4'd0, push_ok};
    wptr_n    = wptr + {3'd0, push_ok};
    rptr_n    = rptr + {3'd0, pop_ok};
    err_n     = err_cnt + {4'd0, push_err} - {4'd0, pop_err};

    if (bus.rWR || bus.rRD || (count == 5'd0))
      idle_n = '0;
    else if (idle_cnt == TW'(TIMEOUT_CYCLES))
      idle_n = idle_cnt;
    else
      idle_n = idle_cnt + 1'b1;
    to_n = !(bus.rWR || bus.rRD) && (to_flag || (idle_n == TW'(TIMEOUT_CYCLES)));

    if (clear) begin
      count_n = '0;
      wptr_n  = '0;
      rptr_n  = '0;
      err_n   = '0;
      idle_n  = '0;
      to_n    = 1'b0;
      overrun = 1'b0;
      push_ok = 1'b0;
    end

    // The new head is the byte being written only when the buffer drains empty this edge.
    if (count_n == 5'd0)
      head_n = '0;
    else if (push_ok && (remain == 5'd0))
      head_n = {bus.fe_in, bus.pe_in, bus.datain};
    else
      head_n = mem[rptr_n];

    lsr_n    = '0;
    lsr_n[0] = (count_n != 5'd0);
    lsr_n[1] = !clear && (overrun || (lsr_q[1] && !bus.lsr_rd));
    lsr_n[2] = head_n[8];
    lsr_n[3] = head_n[9];
    lsr_n[7] = (err_n != 5'd0);

    case (bus.FCR[7:6])
      2'b00:   trig = 5'd1;
      2'b01:   trig = 5'd4;
      2'b10:   trig = 5'd8;
      default: trig = 5'd14;
    endcase

    if (!bus.FCR[0])
      iir_n = 8'h01;
    else if (bus.IER[2] && (lsr_n[1] || lsr_n[2] || lsr_n[3]))
      iir_n = 8'hC6;
    else if (bus.IER[0] && (count_n >= trig))
      iir_n = 8'hC4;
    else if (bus.IER[0] && to_n)
      iir_n = 8'hCC;
    else
      iir_n = 8'hC1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      err_cnt  <= '0;
      idle_cnt <= '0;
      to_flag  <= 1'b0;
      dout_q   <= 8'h00;
      lsr_q    <= 8'h00;
      iir_q    <= 8'h01;
    end else begin
      wptr     <= wptr_n;
      rptr     <= rptr_n;
      count    <= count_n;
      err_cnt  <= err_n;
      idle_cnt <= idle_n;
      to_flag  <= to_n;
      lsr_q    <= lsr_n;
      iir_q    <= iir_n;
      if (pop_ok && !clear)
        dout_q <= pop_entry[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset && push_ok)
      mem[wptr] <= {bus.fe_in, bus.pe_in, bus.datain};
  end
endmodule

// File: tb/tb_uart_rx_buffer.sv
// Directed bench for uart_rx_buffer: the driver queues hand-computed
// {dataout, LSR, IIR} after each edge and a negedge monitor compares them.
module tb_uart_rx_buffer;
  localparam int TO = 64;

  logic clk;
  logic reset;
  uart_rx_buffer_if bus ();

  uart_rx_buffer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard
  logic [23:0] exp_q[$];
  string       name_q[$];
  int          checks = 0;
  int          errors = 0;

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      logic [23:0] e;
      logic [23:0] a;
      string       n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = {bus.dataout, bus.LSR, bus.IIR};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got dataout=%h LSR=%h IIR=%h, expected dataout=%h LSR=%h IIR=%h",
                 n, a[23:16], a[15:8], a[7:0], e[23:16], e[15:8], e[7:0]);
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
    bus.rWR    = 1'b0;
    bus.rRD    = 1'b0;
    bus.lsr_rd = 1'b0;
    bus.pe_in  = 1'b0;
    bus.fe_in  = 1'b0;
  endtask

  task automatic expect_out(input string n, input logic [7:0] d, input logic [7:0] l,
                            input logic [7:0] i);
    exp_q.push_back({d, l, i});
    name_q.push_back(n);
  endtask

  task automatic push(input logic [7:0] b, input logic pe, input logic fe);
    bus.rWR = 1'b1; bus.datain = b; bus.pe_in = pe; bus.fe_in = fe;
    tick();
  endtask

  task automatic pop();
    bus.rRD = 1'b1;
    tick();
  endtask

  initial begin
    bus.rWR = 0; bus.rRD = 0; bus.lsr_rd = 0; bus.datain = 0;
    bus.pe_in = 0; bus.fe_in = 0; bus.FCR = 8'h01; bus.IER = 8'h01;
    reset = 1'b0;
    tick(); tick();
    expect_out("reset", 8'h00, 8'h00, 8'h01);
    reset = 1'b1;
    tick();
    expect_out("idle_enabled", 8'h00, 8'h00, 8'hC1);

    // single byte round trip
    push(8'hA5, 0, 0);
    expect_out("push_a5", 8'h00, 8'h01, 8'hC4);
    pop();
    expect_out("pop_a5", 8'hA5, 8'h00, 8'hC1);
    pop();
    expect_out("pop_empty", 8'hA5, 8'h00, 8'hC1);

    // fill, overrun, drain in order, clear overrun
    for (int i = 0; i < 16; i++) push(8'(i), 0, 0);
    expect_out("full16", 8'hA5, 8'h01, 8'hC4);
    push(8'hFF, 0, 0);
    expect_out("overrun", 8'hA5, 8'h03, 8'hC4);
    for (int i = 0; i < 16; i++) begin
      pop();
      expect_out($sformatf("drain_%0d", i), 8'(i), (i == 15) ? 8'h02 : 8'h03,
                 (i == 15) ? 8'hC1 : 8'hC4);
    end
    pop();
    expect_out("ff_absent", 8'h0F, 8'h02, 8'hC1);
    bus.lsr_rd = 1'b1;
    tick();
    expect_out("lsr_rd_clears_oe", 8'h0F, 8'h00, 8'hC1);

    // simultaneous push and pop while full
    for (int i = 0; i < 16; i++) push(8'h10 + 8'(i), 0, 0);
    bus.rWR = 1'b1; bus.rRD = 1'b1; bus.datain = 8'h77;
    tick();
    expect_out("full_rw", 8'h10, 8'h01, 8'hC4);
    for (int i = 1; i < 16; i++) pop();
    expect_out("full_rw_15pops", 8'h1F, 8'h01, 8'hC4);
    pop();
    expect_out("full_rw_last_77", 8'h77, 8'h00, 8'hC1);

    // trigger level 14 and character timeout
    bus.FCR = 8'hC1;
    for (int i = 0; i < 13; i++) push(8'h20 + 8'(i), 0, 0);
    expect_out("trig14_13", 8'h77, 8'h01, 8'hC1);
    push(8'h2D, 0, 0);
    expect_out("trig14_14", 8'h77, 8'h01, 8'hC4);
    for (int i = 0; i < 11; i++) pop();
    expect_out("down_to_3", 8'h2A, 8'h01, 8'hC1);
    for (int i = 0; i < TO - 1; i++) tick();
    expect_out("timeout_minus1", 8'h2A, 8'h01, 8'hC1);
    tick();
    expect_out("timeout", 8'h2A, 8'h01, 8'hCC);
    tick();
    expect_out("timeout_held", 8'h2A, 8'h01, 8'hCC);
    pop();
    expect_out("timeout_cleared", 8'h2B, 8'h01, 8'hC1);
    pop(); pop();
    expect_out("trig_drained", 8'h2D, 8'h00, 8'hC1);

    // parity error behind a clean byte
    bus.FCR = 8'h01; bus.IER = 8'h04;
    push(8'h30, 0, 0);
    expect_out("clean_push", 8'h2D, 8'h01, 8'hC1);
    push(8'h31, 1, 0);
    expect_out("pe_behind", 8'h2D, 8'h81, 8'hC1);
    pop();
    expect_out("pe_at_head", 8'h30, 8'h85, 8'hC6);
    pop();
    expect_out("pe_popped", 8'h31, 8'h00, 8'hC1);

    // framing error into an empty buffer shows at the head at once
    push(8'h32, 0, 1);
    expect_out("fe_head", 8'h31, 8'h89, 8'hC6);
    pop();
    expect_out("fe_popped", 8'h32, 8'h00, 8'hC1);

    // FIFO clear, FIFO disable, then reset mid-stream
    bus.IER = 8'h01;
    for (int i = 0; i < 5; i++) push(8'h40 + 8'(i), 0, 0);
    expect_out("five", 8'h32, 8'h01, 8'hC4);
    bus.FCR = 8'h03;
    tick();
    expect_out("fcr_clear", 8'h32, 8'h00, 8'hC1);
    bus.FCR = 8'h01;
    pop();
    expect_out("after_clear_empty", 8'h32, 8'h00, 8'hC1);
    push(8'h50, 0, 0);
    bus.FCR = 8'h00;
    tick();
    expect_out("fifo_disable", 8'h32, 8'h00, 8'h01);
    bus.FCR = 8'h01;
    push(8'h51, 0, 0);
    push(8'h52, 0, 0);
    expect_out("pre_reset", 8'h32, 8'h01, 8'hC4);
    reset = 1'b0;
    bus.rWR = 1'b1; bus.datain = 8'h53;
    tick();
    expect_out("mid_reset", 8'h00, 8'h00, 8'h01);
    reset = 1'b1;
    pop();
    expect_out("post_reset_empty", 8'h00, 8'h00, 8'hC1);

    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_queue: %0d expectations unchecked, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
